// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for an 8-master tristate bus: one-hot output enables,
// encoded mux select, a one-cycle turnaround between owners and an optional hold limit.
module bus_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD);

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  ptr_r;
    logic [2:0]  ptr_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic [2:0]  cand_s;
    logic [2:0]  win_idx_s;
    logic        win_valid_s;
    logic [7:0]  grant_s;
    logic [2:0]  idx_s;
    logic        valid_s;
    logic        timeout_s;
    logic        busy_s;
    logic        limit_s;
    logic        release_s;

    // Rotating priority search starting at ptr_r
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = 3'd0;
        cand_s      = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand_s = ptr_r + 3'(k);
            if (!win_valid_s && req[cand_s]) begin
                win_valid_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Next-state and next-output logic; grant_idx holds the current owner
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        grant_s   = 8'd0;
        idx_s     = 3'd0;
        valid_s   = 1'b0;
        timeout_s = 1'b0;
        limit_s   = (HOLD_LIMIT != 16'd0) && (cnt_r == HOLD_LIMIT);
        release_s = done[grant_idx] || !req[grant_idx] || limit_s;
        case (state_r)
            IDLE, TURN: begin
                if (win_valid_s) begin
                    state_s = GRANT;
                    grant_s = 8'd1 << win_idx_s;
                    idx_s   = win_idx_s;
                    valid_s = 1'b1;
                    cnt_s   = 16'd1;
                end else begin
                    state_s = IDLE;
                    cnt_s   = 16'd0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_s   = TURN;
                    ptr_s     = grant_idx + 3'd1;
                    cnt_s     = 16'd0;
                    // Only a pure limit expiry counts as a forced release
                    timeout_s = limit_s && !done[grant_idx] && req[grant_idx];
                end else begin
                    grant_s = grant;
                    idx_s   = grant_idx;
                    valid_s = 1'b1;
                    cnt_s   = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 16'd0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= IDLE;
            ptr_r       <= 3'd0;
            cnt_r       <= 16'd0;
            grant       <= 8'd0;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            cnt_r       <= cnt_s;
            grant       <= grant_s;
            grant_idx   <= idx_s;
            grant_valid <= valid_s;
            timeout     <= timeout_s;
            busy        <= busy_s;
        end
    end

endmodule
